// File: rtl/mem_stage_if.sv
// Execute/SRAM/writeback-facing signal bundle of the memory-response stage.
// slave = the stage itself, master = the surrounding pipeline that drives it.
interface mem_stage_if;
  logic        es_to_ms_valid;
  logic        ms_allowin;
  logic [31:0] es_pc;
  logic [31:0] es_result;
  logic [4:0]  es_dest;
  logic        es_gr_we;
  logic        es_res_from_mem;
  logic [4:0]  es_load_op;
  logic        es_mem_req;
  logic        es_ex;
  logic [5:0]  es_ecode;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        ms_flush_pipe;
  logic        ws_allowin;
  logic        ms_to_ws_valid;
  logic [31:0] ms_pc;
  logic [31:0] ms_final_result;
  logic [4:0]  ms_dest;
  logic        ms_gr_we;
  logic        ms_ex_out;
  logic [5:0]  ms_ecode_out;
  logic        ms_ex;
  logic        ms_fwd_valid;
  logic        ms_blk_valid;
  logic [4:0]  ms_fwd_dest;
  logic [31:0] ms_fwd_data;

  modport master (
    output es_to_ms_valid, es_pc, es_result, es_dest, es_gr_we, es_res_from_mem,
           es_load_op, es_mem_req, es_ex, es_ecode, data_sram_data_ok,
           data_sram_rdata, ms_flush_pipe, ws_allowin,
    input  ms_allowin, ms_to_ws_valid, ms_pc, ms_final_result, ms_dest, ms_gr_we,
           ms_ex_out, ms_ecode_out, ms_ex, ms_fwd_valid, ms_blk_valid,
           ms_fwd_dest, ms_fwd_data
  );

  modport slave (
    input  es_to_ms_valid, es_pc, es_result, es_dest, es_gr_we, es_res_from_mem,
           es_load_op, es_mem_req, es_ex, es_ecode, data_sram_data_ok,
           data_sram_rdata, ms_flush_pipe, ws_allowin,
    output ms_allowin, ms_to_ws_valid, ms_pc, ms_final_result, ms_dest, ms_gr_we,
           ms_ex_out, ms_ecode_out, ms_ex, ms_fwd_valid, ms_blk_valid,
           ms_fwd_dest, ms_fwd_data
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-response pipeline stage: waits for the in-order SRAM data_ok, aligns/extends loads.
// Latency 1 cycle for non-memory ops; memory ops complete in the data_ok cycle; stalls on ws_allowin=0.
module mem_stage (
  input logic       clk,
  input logic       reset,
  mem_stage_if.slave bus
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] result;
    logic [4:0]  dest;
    logic        gr_we;
    logic        res_from_mem;
    logic [4:0]  load_op;
    logic        mem_req;
    logic        ex;
    logic [5:0]  ecode;
  } ms_inst_t;

  ms_inst_t    inst_q, inst_d;
  logic        ms_valid_q, ms_valid_d;
  logic        cancel_q, cancel_d;
  logic        data_buf_valid_q, data_buf_valid_d;
  logic [31:0] data_buf_q, data_buf_d;

  logic        resp_now;
  logic        ms_ready_go;
  logic        to_ws_valid;
  logic        allowin;
  logic        leave;
  logic [31:0] rdata_sel;
  logic [31:0] byte_word;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_data;
  logic [31:0] final_result;
  logic        gr_we_out;

  // A cancelled slot swallows the next response, so it never counts as ours.
  assign resp_now    = bus.data_sram_data_ok & ~cancel_q & ~data_buf_valid_q;
  assign ms_ready_go = ~inst_q.mem_req | data_buf_valid_q | resp_now;
  assign to_ws_valid = ms_valid_q & ms_ready_go & ~bus.ms_flush_pipe;
  assign allowin     = ~ms_valid_q | (ms_ready_go & bus.ws_allowin);
  assign leave       = to_ws_valid & bus.ws_allowin;

  always_comb begin
    ms_valid_d       = ms_valid_q;
    inst_d           = inst_q;
    cancel_d         = cancel_q;
    data_buf_valid_d = data_buf_valid_q;
    data_buf_d       = data_buf_q;

    if (bus.ms_flush_pipe) begin
      ms_valid_d = 1'b0;
    end else if (allowin) begin
      ms_valid_d = bus.es_to_ms_valid;
    end

    if (bus.es_to_ms_valid & allowin & ~bus.ms_flush_pipe) begin
      inst_d.pc           = bus.es_pc;
      inst_d.result       = bus.es_result;
      inst_d.dest         = bus.es_dest;
      inst_d.gr_we        = bus.es_gr_we;
      inst_d.res_from_mem = bus.es_res_from_mem;
      inst_d.load_op      = bus.es_load_op;
      inst_d.mem_req      = bus.es_mem_req;
      inst_d.ex           = bus.es_ex;
      inst_d.ecode        = bus.es_ecode;
    end

    if (leave | bus.ms_flush_pipe) begin
      data_buf_valid_d = 1'b0;
      data_buf_d       = 32'd0;
    end else if (bus.data_sram_data_ok & ~cancel_q & ms_valid_q & inst_q.mem_req
                 & ~data_buf_valid_q) begin
      data_buf_valid_d = 1'b1;
      data_buf_d       = bus.data_sram_rdata;
    end

    // Set only when no data_ok this cycle, so set and clear are exclusive.
    if (bus.ms_flush_pipe & ms_valid_q & inst_q.mem_req & ~data_buf_valid_q
        & ~bus.data_sram_data_ok) begin
      cancel_d = 1'b1;
    end else if (bus.data_sram_data_ok) begin
      cancel_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_valid_q       <= 1'b0;
      inst_q           <= '0;
      cancel_q         <= 1'b0;
      data_buf_valid_q <= 1'b0;
      data_buf_q       <= 32'd0;
    end else begin
      ms_valid_q       <= ms_valid_d;
      inst_q           <= inst_d;
      cancel_q         <= cancel_d;
      data_buf_valid_q <= data_buf_valid_d;
      data_buf_q       <= data_buf_d;
    end
  end

  assign rdata_sel = data_buf_valid_q ? data_buf_q : bus.data_sram_rdata;
  assign byte_word = rdata_sel >> {inst_q.result[1:0], 3'b000};
  assign lane_b    = byte_word[7:0];
  assign lane_h    = inst_q.result[1] ? rdata_sel[31:16] : rdata_sel[15:0];

  always_comb begin
    load_data = 32'd0;
    if (inst_q.load_op[0]) begin
      load_data = {{24{lane_b[7]}}, lane_b};
    end else if (inst_q.load_op[1]) begin
      load_data = {{16{lane_h[15]}}, lane_h};
    end else if (inst_q.load_op[2]) begin
      load_data = rdata_sel;
    end else if (inst_q.load_op[3]) begin
      load_data = {24'd0, lane_b};
    end else if (inst_q.load_op[4]) begin
      load_data = {16'd0, lane_h};
    end
  end

  assign final_result = inst_q.res_from_mem ? load_data : inst_q.result;
  assign gr_we_out    = inst_q.gr_we & ~inst_q.ex;

  assign bus.ms_allowin      = allowin;
  assign bus.ms_to_ws_valid  = to_ws_valid;
  assign bus.ms_pc           = inst_q.pc;
  assign bus.ms_final_result = final_result;
  assign bus.ms_dest         = inst_q.dest;
  assign bus.ms_gr_we        = gr_we_out;
  assign bus.ms_ex_out       = inst_q.ex;
  assign bus.ms_ecode_out    = inst_q.ecode;
  assign bus.ms_ex           = ms_valid_q & inst_q.ex;
  assign bus.ms_fwd_valid    = to_ws_valid & gr_we_out;
  assign bus.ms_blk_valid    = ms_valid_q & inst_q.res_from_mem & ~ms_ready_go;
  assign bus.ms_fwd_dest     = inst_q.dest;
  assign bus.ms_fwd_data     = final_result;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vectors with literal expectations plus a
// transaction-level model (owed-response counter, per-instruction response slot) checked every cycle.
module tb_mem_stage;
  logic clk;
  logic reset;
  mem_stage_if bus ();

  mem_stage dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] result;
    logic [4:0]  dest;
    logic        gr_we;
    logic        rfm;
    logic [4:0]  op;
    logic        mreq;
    logic        ex;
    logic [5:0]  ecode;
  } tb_inst_t;

  // Model: at most one instruction resident, its response (once seen),
  // and a count of responses owed to flushed instructions.
  tb_inst_t    m_ins;
  logic        m_valid;
  logic        m_got;
  logic [31:0] m_data;
  int          m_drop;

  function automatic logic [31:0] exp_load(input logic [4:0] op, input logic [31:0] addr,
                                           input logic [31:0] w);
    logic [31:0] bt;
    logic [31:0] hf;
    bt = (w >> ((addr % 4) * 8)) & 32'hFF;
    hf = (w >> ((addr % 4) / 2 * 16)) & 32'hFFFF;
    case (op)
      5'b00001: return (bt >= 128) ? bt - 32'd256 : bt;
      5'b00010: return (hf >= 32768) ? hf - 32'd65536 : hf;
      5'b00100: return w;
      5'b01000: return bt;
      5'b10000: return hf;
      default:  return 32'd0;
    endcase
  endfunction

  initial begin
    m_valid = 1'b0;
    m_got   = 1'b0;
    m_data  = 32'd0;
    m_drop  = 0;
    m_ins   = '0;
  end

  always @(negedge clk) begin
    logic        done, e_tows, e_allow, m_wait;
    logic [31:0] word, e_res;
    if (reset) begin
      m_valid = 1'b0;
      m_got   = 1'b0;
      m_drop  = 0;
      chk("m_rst_allowin", bus.ms_allowin, 1);
      chk("m_rst_tows", bus.ms_to_ws_valid, 0);
    end else begin
      m_wait  = m_valid && m_ins.mreq && !m_got;
      done    = m_valid && (!m_ins.mreq || m_got || (bus.data_sram_data_ok && m_drop == 0));
      e_tows  = done && !bus.ms_flush_pipe;
      e_allow = !m_valid || (done && bus.ws_allowin);
      word    = m_got ? m_data : bus.data_sram_rdata;
      e_res   = m_ins.rfm ? exp_load(m_ins.op, m_ins.result, word) : m_ins.result;
      chk("m_allowin", bus.ms_allowin, e_allow);
      chk("m_tows", bus.ms_to_ws_valid, e_tows);
      chk("m_ms_ex", bus.ms_ex, m_valid && m_ins.ex);
      chk("m_blk", bus.ms_blk_valid, m_valid && m_ins.rfm && !done);
      chk("m_fwd_valid", bus.ms_fwd_valid, e_tows && m_ins.gr_we && !m_ins.ex);
      if (m_valid) begin
        chk("m_pc", bus.ms_pc, m_ins.pc);
        chk("m_dest", bus.ms_dest, m_ins.dest);
        chk("m_fwd_dest", bus.ms_fwd_dest, m_ins.dest);
        chk("m_gr_we", bus.ms_gr_we, m_ins.gr_we && !m_ins.ex);
        chk("m_ex_out", bus.ms_ex_out, m_ins.ex);
        chk("m_ecode", bus.ms_ecode_out, m_ins.ecode);
      end
      if (e_tows) begin
        chk("m_result", bus.ms_final_result, e_res);
        chk("m_fwd_data", bus.ms_fwd_data, e_res);
      end
      if (bus.data_sram_data_ok) begin
        if (m_drop > 0) m_drop--;
        else if (m_wait) begin
          m_got  = 1'b1;
          m_data = bus.data_sram_rdata;
        end
      end
      if (bus.ms_flush_pipe) begin
        if (m_wait && !bus.data_sram_data_ok) m_drop++;
        m_valid = 1'b0;
      end else begin
        if (e_tows && bus.ws_allowin) m_valid = 1'b0;
        if (e_allow && bus.es_to_ms_valid) begin
          m_valid = 1'b1;
          m_got   = 1'b0;
          m_ins   = '{bus.es_pc, bus.es_result, bus.es_dest, bus.es_gr_we,
                      bus.es_res_from_mem, bus.es_load_op, bus.es_mem_req,
                      bus.es_ex, bus.es_ecode};
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic send(input logic [31:0] pc, input logic [31:0] res, input logic [4:0] dest,
                      input logic gr_we, input logic rfm, input logic [4:0] op,
                      input logic mreq, input logic ex, input logic [5:0] ec);
    bus.es_to_ms_valid  = 1'b1;
    bus.es_pc           = pc;
    bus.es_result       = res;
    bus.es_dest         = dest;
    bus.es_gr_we        = gr_we;
    bus.es_res_from_mem = rfm;
    bus.es_load_op      = op;
    bus.es_mem_req      = mreq;
    bus.es_ex           = ex;
    bus.es_ecode        = ec;
    #1;
    for (int i = 0; i < 20 && !bus.ms_allowin; i++) begin
      step();
      #1;
    end
    chk("send_accept", bus.ms_allowin, 1);
    step();
    bus.es_to_ms_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    bus.es_to_ms_valid    = 0;
    bus.es_pc             = 0;
    bus.es_result         = 0;
    bus.es_dest           = 0;
    bus.es_gr_we          = 0;
    bus.es_res_from_mem   = 0;
    bus.es_load_op        = 0;
    bus.es_mem_req        = 0;
    bus.es_ex             = 0;
    bus.es_ecode          = 0;
    bus.data_sram_data_ok = 0;
    bus.data_sram_rdata   = 0;
    bus.ms_flush_pipe     = 0;
    bus.ws_allowin        = 1;
    #1 reset = 1'b1;
    #1;
    chk("rst_allowin", bus.ms_allowin, 1);
    chk("rst_tows", bus.ms_to_ws_valid, 0);
    chk("rst_pc", bus.ms_pc, 0);
    chk("rst_result", bus.ms_final_result, 0);
    chk("rst_dest", bus.ms_dest, 0);
    chk("rst_gr_we", bus.ms_gr_we, 0);
    chk("rst_ex_out", bus.ms_ex_out, 0);
    chk("rst_ecode", bus.ms_ecode_out, 0);
    chk("rst_ms_ex", bus.ms_ex, 0);
    chk("rst_fwd_valid", bus.ms_fwd_valid, 0);
    chk("rst_blk", bus.ms_blk_valid, 0);
    chk("rst_fwd_dest", bus.ms_fwd_dest, 0);
    chk("rst_fwd_data", bus.ms_fwd_data, 0);
    step();
    step();
    reset = 1'b0;

    // ALU op: one-cycle latency
    send(32'h100, 32'h1234, 5'd3, 1, 0, 5'b0, 0, 0, 6'd0);
    settle();
    chk("alu_tows", bus.ms_to_ws_valid, 1);
    chk("alu_result", bus.ms_final_result, 32'h1234);
    chk("alu_fwd_valid", bus.ms_fwd_valid, 1);
    step();

    // ld.b at 0x1003, data_ok two cycles after entry
    send(32'h104, 32'h1003, 5'd4, 1, 1, 5'b00001, 1, 0, 6'd0);
    settle();
    chk("ldb_blk0", bus.ms_blk_valid, 1);
    chk("ldb_tows0", bus.ms_to_ws_valid, 0);
    step();
    bus.data_sram_data_ok = 1;
    bus.data_sram_rdata   = 32'h80FF_0000;
    settle();
    chk("ldb_tows", bus.ms_to_ws_valid, 1);
    chk("ldb_result", bus.ms_final_result, 32'hFFFF_FF80);
    chk("ldb_blk1", bus.ms_blk_valid, 0);
    step();
    bus.data_sram_data_ok = 0;

    // ld.hu at 0x1002, data_ok in the entry cycle
    send(32'h108, 32'h1002, 5'd5, 1, 1, 5'b10000, 1, 0, 6'd0);
    bus.data_sram_data_ok = 1;
    settle();
    chk("ldhu_result", bus.ms_final_result, 32'h0000_80FF);
    step();
    bus.data_sram_data_ok = 0;

    // ld.w response buffered while writeback stalls
    bus.ws_allowin = 0;
    send(32'h10C, 32'h2000, 5'd6, 1, 1, 5'b00100, 1, 0, 6'd0);
    bus.data_sram_data_ok = 1;
    bus.data_sram_rdata   = 32'hDEAD_BEEF;
    settle();
    chk("buf_tows0", bus.ms_to_ws_valid, 1);
    chk("buf_result0", bus.ms_final_result, 32'hDEAD_BEEF);
    chk("buf_allowin0", bus.ms_allowin, 0);
    step();
    bus.data_sram_data_ok = 0;
    bus.data_sram_rdata   = 32'hAAAA_AAAA;
    settle();
    chk("buf_result1", bus.ms_final_result, 32'hDEAD_BEEF);
    step();
    bus.ws_allowin = 1;
    settle();
    chk("buf_result2", bus.ms_final_result, 32'hDEAD_BEEF);
    chk("buf_allowin2", bus.ms_allowin, 1);
    step();
    settle();
    chk("buf_gone", bus.ms_to_ws_valid, 0);
    step();

    // flush with response owed: next data_ok dropped
    send(32'h110, 32'h3000, 5'd7, 1, 1, 5'b00100, 1, 0, 6'd0);
    bus.ms_flush_pipe = 1;
    settle();
    chk("fl_tows", bus.ms_to_ws_valid, 0);
    step();
    bus.ms_flush_pipe = 0;
    send(32'h114, 32'h3004, 5'd8, 1, 1, 5'b00100, 1, 0, 6'd0);
    bus.data_sram_data_ok = 1;
    bus.data_sram_rdata   = 32'h11;
    settle();
    chk("fl_drop_tows", bus.ms_to_ws_valid, 0);
    chk("fl_drop_blk", bus.ms_blk_valid, 1);
    step();
    bus.data_sram_rdata = 32'h22;
    settle();
    chk("fl_tows2", bus.ms_to_ws_valid, 1);
    chk("fl_result", bus.ms_final_result, 32'h22);
    step();
    bus.data_sram_data_ok = 0;

    // flush coinciding with data_ok: nothing left owed
    send(32'h118, 32'h4000, 5'd9, 1, 1, 5'b00100, 1, 0, 6'd0);
    bus.data_sram_data_ok = 1;
    bus.data_sram_rdata   = 32'h55;
    bus.ms_flush_pipe     = 1;
    settle();
    chk("flok_tows", bus.ms_to_ws_valid, 0);
    step();
    bus.data_sram_data_ok = 0;
    bus.ms_flush_pipe     = 0;
    send(32'h11C, 32'h4004, 5'd10, 1, 1, 5'b00100, 1, 0, 6'd0);
    bus.data_sram_data_ok = 1;
    bus.data_sram_rdata   = 32'h66;
    settle();
    chk("flok_tows2", bus.ms_to_ws_valid, 1);
    chk("flok_result", bus.ms_final_result, 32'h66);
    step();
    bus.data_sram_data_ok = 0;

    // store waits for data_ok, result is the address
    send(32'h120, 32'h5000, 5'd0, 0, 0, 5'b0, 1, 0, 6'd0);
    settle();
    chk("st_wait", bus.ms_to_ws_valid, 0);
    chk("st_blk", bus.ms_blk_valid, 0);
    step();
    bus.data_sram_data_ok = 1;
    bus.data_sram_rdata   = 32'h1234;
    settle();
    chk("st_tows", bus.ms_to_ws_valid, 1);
    chk("st_result", bus.ms_final_result, 32'h5000);
    step();
    bus.data_sram_data_ok = 0;

    // exception passes straight through
    send(32'h124, 32'h0, 5'd11, 1, 0, 5'b0, 0, 1, 6'h9);
    settle();
    chk("ex_out", bus.ms_ex_out, 1);
    chk("ex_ecode", bus.ms_ecode_out, 6'h9);
    chk("ex_gr_we", bus.ms_gr_we, 0);
    chk("ex_ms_ex", bus.ms_ex, 1);
    chk("ex_tows", bus.ms_to_ws_valid, 1);
    step();

    // asynchronous reset while a load waits
    send(32'h128, 32'h6000, 5'd12, 1, 1, 5'b00100, 1, 0, 6'd0);
    settle();
    chk("ar_blk", bus.ms_blk_valid, 1);
    step();
    #2 reset = 1'b1;
    #1;
    chk("ar_tows", bus.ms_to_ws_valid, 0);
    chk("ar_blk0", bus.ms_blk_valid, 0);
    step();
    step();
    reset = 1'b0;
    settle();
    chk("ar_allowin", bus.ms_allowin, 1);
    step();
    send(32'h12C, 32'hABC, 5'd13, 1, 0, 5'b0, 0, 0, 6'd0);
    settle();
    chk("ar_alu_result", bus.ms_final_result, 32'hABC);
    chk("ar_alu_tows", bus.ms_to_ws_valid, 1);
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-response stage of the five-stage LoongArch pipeline, between the execute stage and the writeback stage. Accepts each instruction from execute, waits for the data-SRAM `data_ok` of any memory request that execute issued, then aligns and extends load data. Hands the final result to writeback and drives forwarding/blocking information back to decode. Discards responses that belong to flushed instructions, so the in-order SRAM response stream stays matched to its instructions.

## Interface
Parameters: none.

- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high reset
- `es_to_ms_valid`  in  1  execute holds a valid instruction for this stage
- `ms_allowin`  out  1  stage can accept an instruction this cycle
- `es_pc`  in  32  instruction PC
- `es_result`  in  32  ALU/mul/div/counter result; for memory ops, the byte address
- `es_dest`  in  5  destination GPR
- `es_gr_we`  in  1  instruction writes a GPR
- `es_res_from_mem`  in  1  result comes from load data
- `es_load_op`  in  5  one-hot load type: [0] ld.b, [1] ld.h, [2] ld.w, [3] ld.bu, [4] ld.hu
- `es_mem_req`  in  1  execute issued an SRAM request that was accepted (`addr_ok`)
- `es_ex`  in  1  instruction already carries an exception
- `es_ecode`  in  6  exception code
- `data_sram_data_ok`  in  1  one SRAM response this cycle, returned in request order
- `data_sram_rdata`  in  32  response data, valid with `data_ok`
- `ms_flush_pipe`  in  1  exception/ertn flush from writeback
- `ws_allowin`  in  1  writeback can accept
- `ms_to_ws_valid`  out  1  result is valid for writeback
- `ms_pc`, `ms_final_result`  out  32 each  PC and final result
- `ms_dest`  out  5  destination GPR
- `ms_gr_we`  out  1  GPR write enable, forced to 0 when `ms_ex_out` is 1
- `ms_ex_out`  out  1  exception flag passed to writeback
- `ms_ecode_out`  out  6  exception code passed to writeback
- `ms_ex`  out  1  `ms_valid & ms_ex_l`; tells execute to suppress new requests
- `ms_fwd_valid`  out  1  `ms_to_ws_valid & ms_gr_we`
- `ms_blk_valid`  out  1  `ms_valid & ms_res_from_mem & ~ms_ready_go`; decode must stall
- `ms_fwd_dest`  out  5  equals `ms_dest`
- `ms_fwd_data`  out  32  equals `ms_final_result`

## Operation
**Pipeline register**
- `ms_valid` loads as follows:
  - 0 on flush;
  - otherwise `es_to_ms_valid` when `ms_allowin` is 1.
- All `es_*` fields latch into the `ms_*_l` registers when `es_to_ms_valid & ms_allowin & ~ms_flush_pipe`.

**Response capture**
- `data_buf_valid` and `data_buf` capture `rdata` when `data_ok & ~cancel & ms_valid & ms_mem_req_l & ~data_buf_valid`.
- Both clear when the instruction leaves the stage (`ms_to_ws_valid & ws_allowin`) or on flush.
- `resp_now = data_ok & ~cancel & ~data_buf_valid`.
- `ms_ready_go = ~ms_mem_req_l | data_buf_valid | resp_now`.
- `ms_to_ws_valid = ms_valid & ms_ready_go & ~ms_flush_pipe`.
- `ms_allowin = ~ms_valid | (ms_ready_go & ws_allowin)`.

**Cancel flag**
- Set on `ms_flush_pipe & ms_valid & ms_mem_req_l & ~data_buf_valid & ~data_ok`, i.e. a response is still owed to the flushed instruction.
- Cleared by the next `data_ok`; that response is dropped.
- Set and clear never coincide, because setting requires `~data_ok`.

**Load data**
- `rdata_sel = data_buf_valid ? data_buf : data_sram_rdata`.
- Byte lane is `rdata_sel >> (8*ms_result_l[1:0])`.
- Halfword uses lane `ms_result_l[1]`.
- ld.b/ld.h sign-extend; ld.bu/ld.hu zero-extend; ld.w passes all 32 bits.
- `ms_final_result = ms_res_from_mem_l ? load_data : ms_result_l`.
- Stores with `mem_req` wait for `data_ok`; the response data is ignored.

**Exception case**
- When `es_ex` is set, execute never issues a request, so `es_mem_req` is 0 and the instruction passes straight through.

## Timing
- Reset values:
  - `ms_valid`, `cancel`, `data_buf_valid` = 0;
  - `data_buf` and `ms_*_l` = 0;
  - so `ms_allowin` = 1 and every other output = 0.
- Non-memory instruction: accepted at edge N, `ms_to_ws_valid` high in cycle N+1 (1-cycle latency).
- Memory instruction: `ms_to_ws_valid` asserts combinationally in the cycle `data_ok` arrives, or in any later cycle if the response is buffered.
- A `data_ok` arriving while `ws_allowin` is 0 is buffered. The result then holds stable until the handshake, and a buffered response is never overwritten.
- Flush in the same cycle as `data_ok` for the current instruction: the response is consumed and `cancel` stays 0.
- Flush with the response still owed: `cancel` is set. A new memory instruction may enter immediately, and its response is the second `data_ok` after the flush.
- Reset mid-transaction: all state clears asynchronously, and no pending response is tracked.

## Test plan
- ALU op: `es_result` = 0x1234, `es_gr_we` = 1, `ws_allowin` = 1 → next cycle `ms_to_ws_valid` = 1, `ms_final_result` = 0x1234, `ms_fwd_valid` = 1.
- ld.b, address 0x1003, `data_ok` 2 cycles after entry with `rdata` = 0x80FF_0000 → `ms_blk_valid` = 1 while waiting; `ms_final_result` = 0xFFFF_FF80 in the `data_ok` cycle. ld.hu at address 0x1002 with the same data → 0x0000_80FF.
- `ws_allowin` = 0 when `data_ok` arrives with `rdata` = 0xDEADBEEF (ld.w), then 0xAAAAAAAA on the bus the next cycle → after `ws_allowin` rises, result = 0xDEADBEEF.
- Flush while a ld.w is waiting with no `data_ok`; a new ld.w enters; two `data_ok` with 0x11, then 0x22 → first dropped, result = 0x22.
- `es_ex` = 1, `es_ecode` = 0x9, `es_gr_we` = 1 → `ms_ex_out` = 1, `ms_ecode_out` = 0x9, `ms_gr_we` = 0, `ms_ex` = 1, no wait for `data_ok`.
- Assert `reset` asynchronously mid-wait → `ms_to_ws_valid` = 0 immediately; `ms_allowin` = 1 once `reset` releases.
